// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// One result bit per cycle (32 iterations), then a fix-up cycle that applies
// sign correction and special cases and issues a single-cycle RegFile write.
// Fixed latency of 34 cycles from the start cycle to the done cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] din,
   output logic [4:0]      rd,
   output logic            r
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]      r_state;
   logic [5:0]      r_cnt;
   logic [2:0]      r_op;
   logic [4:0]      r_rd_cap;
   logic            r_neg_a;
   logic            r_neg_b;
   logic            r_b_zero;
   // r_hi/r_lo: product {hi,lo} for multiply; remainder/quotient for divide.
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   // r_opnd: multiplicand for multiply, divisor for divide (magnitudes).
   logic [XLEN-1:0] r_opnd;
   logic            r_busy;
   logic            r_done;
   logic            r_wr_n;
   logic [XLEN-1:0] r_din;
   logic [4:0]      r_rd;

   // Operand signedness decoded from the incoming funct3.
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;

   assign w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
   assign w_b_signed = op[2] ? ~op[0] : ~op[1];
   assign w_a_neg    = w_a_signed & a[XLEN-1];
   assign w_b_neg    = w_b_signed & b[XLEN-1];
   assign w_a_mag    = w_a_neg ? -a : a;
   assign w_b_mag    = w_b_neg ? -b : b;

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit (LSB of r_lo) is set, then shift the pair right by one.
   logic [XLEN:0]   w_mul_sum;
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});

   // Restoring step: shift next dividend bit into the partial remainder and
   // subtract the divisor if it fits. The remainder never exceeds 32 bits.
   logic [XLEN:0]   w_div_shift;
   logic            w_div_ok;
   logic [XLEN-1:0] w_div_sub;
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
   assign w_div_sub   = w_div_shift[XLEN-1:0] - r_opnd;

   // Fix-up: sign correction of magnitude results and divide-by-zero quotient.
   // Divide-by-zero naturally leaves |a| in the remainder, so restoring the
   // sign of a returns a unmodified. Signed overflow needs no special path:
   // |0x80000000|/1 with matching signs yields 0x80000000 remainder 0.
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_result;

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
   assign w_quo    = r_b_zero ? {XLEN{1'b1}} : ((r_neg_a ^ r_neg_b) ? -r_lo : r_lo);
   assign w_rem    = r_neg_a ? -r_hi : r_hi;

   // Select the final result for the captured operation.
   always_comb begin
      w_result = w_prod_s[XLEN-1:0];
      case (r_op)
         3'b000:                 w_result = w_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_result = w_prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_result = w_quo;
         default:                w_result = w_rem;
      endcase
   end

   // Control FSM and write-back outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 6'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wr_n   <= 1'b1;
         r_din    <= '0;
         r_rd     <= 5'd0;
         r_op     <= 3'd0;
         r_rd_cap <= 5'd0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_b_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wr_n <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op     <= op;
                  r_rd_cap <= rd_in;
                  r_neg_a  <= w_a_neg;
                  r_neg_b  <= w_b_neg;
                  r_b_zero <= (b == '0);
                  r_cnt    <= 6'd0;
                  r_busy   <= 1'b1;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'(XLEN - 1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_din   <= w_result;
               r_rd    <= r_rd_cap;
               r_done  <= 1'b1;
               r_wr_n  <= (r_rd_cap == 5'd0);
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Datapath: operand capture and one multiply/divide iteration per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_opnd <= '0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_hi   <= '0;
            r_lo   <= op[2] ? w_a_mag : w_b_mag;
            r_opnd <= op[2] ? w_b_mag : w_a_mag;
         end
      end else if (r_state == S_BUSY) begin
         if (r_op[2]) begin
            if (w_div_ok) begin
               r_hi <= w_div_sub;
               r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
               r_hi <= w_div_shift[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
         end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign din  = r_din;
   assign rd   = r_rd;
   assign r    = r_wr_n;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model with a cycle-accurate expectation scoreboard.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] din;
   logic [4:0]  rd;
   logic        r;

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .rd_in (rd_in),
      .busy  (busy),
      .done  (done),
      .din   (din),
      .rd    (rd),
      .r     (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc = number of rising edges seen; the interval after edge k has cyc=k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          start_cyc;
      logic [31:0] res;
      logic [4:0]  rd;
   } pend_t;

   pend_t       pend_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 1'b0;
   logic [31:0] exp_din  = 32'd0;
   logic [4:0]  exp_rd   = 5'd0;

   // Reference arithmetic straight from the RV32M rules.
   function automatic logic [31:0] model(input logic [2:0] f_op, input logic [31:0] f_a,
                                         input logic [31:0] f_b);
      longint          sp;
      longint unsigned up;
      int              sa;
      int              sb;
      int              q;
      sa = f_a;
      sb = f_b;
      case (f_op)
         3'd0: begin
            up = {32'd0, f_a} * {32'd0, f_b};
            return up[31:0];
         end
         3'd1: begin
            sp = longint'(sa) * longint'(sb);
            return sp[63:32];
         end
         3'd2: begin
            sp = longint'(sa) * longint'({32'd0, f_b});
            return sp[63:32];
         end
         3'd3: begin
            up = {32'd0, f_a} * {32'd0, f_b};
            return up[63:32];
         end
         3'd4: begin
            if (f_b == 32'd0) return 32'hFFFFFFFF;
            if (f_a == 32'h80000000 && f_b == 32'hFFFFFFFF) return 32'h80000000;
            q = sa / sb;
            return q;
         end
         3'd5: begin
            if (f_b == 32'd0) return 32'hFFFFFFFF;
            return f_a / f_b;
         end
         3'd6: begin
            if (f_b == 32'd0) return f_a;
            if (f_a == 32'h80000000 && f_b == 32'hFFFFFFFF) return 32'd0;
            q = sa % sb;
            return q;
         end
         default: begin
            if (f_b == 32'd0) return f_a;
            return f_a % f_b;
         end
      endcase
   endfunction

   // An accepted op is busy from the interval after its start edge through 33 intervals.
   function automatic bit model_busy(input int c);
      foreach (pend_q[i]) begin
         if (c >= pend_q[i].start_cyc + 1 && c <= pend_q[i].start_cyc + 33) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, cyc, act, expv);
      end
   endtask

   // Compare process: every cycle after reset, outputs against the scoreboard.
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_done;
         logic exp_busy;
         logic exp_r;
         exp_done = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].start_cyc + 34 == cyc) begin
            exp_done = 1'b1;
            exp_din  = pend_q[0].res;
            exp_rd   = pend_q[0].rd;
            void'(pend_q.pop_front());
            $display("txn cyc=%0d rd=%0d din=%08h expected=%08h", cyc, rd, din, exp_din);
         end
         exp_busy = model_busy(cyc);
         exp_r    = !(exp_done && exp_rd != 5'd0);
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("r",    32'(r),    32'(exp_r));
         check("din",  din,       exp_din);
         check("rd",   32'(rd),   32'(exp_rd));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Present a start for one cycle; the model decides whether it is accepted.
   task automatic issue(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b,
                        input logic [4:0] f_rd);
      pend_t p;
      start = 1'b1;
      op    = f_op;
      a     = f_a;
      b     = f_b;
      rd_in = f_rd;
      if (!rst && !model_busy(cyc)) begin
         p.start_cyc = cyc;
         p.res       = model(f_op, f_a, f_b);
         p.rd        = f_rd;
         pend_q.push_back(p);
      end
      step(1);
      start = 1'b0;
      op    = 3'($urandom_range(7));
      a     = $urandom;
      b     = $urandom;
      rd_in = 5'($urandom_range(31));
   endtask

   // Directed op whose expected result is also pinned by a hand-computed literal.
   task automatic issue_lit(input string name, input logic [2:0] f_op, input logic [31:0] f_a,
                            input logic [31:0] f_b, input logic [4:0] f_rd,
                            input logic [31:0] lit);
      check(name, model(f_op, f_a, f_b), lit);
      issue(f_op, f_a, f_b, f_rd);
      step(36);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      pend_q.delete();
      exp_din = 32'd0;
      exp_rd  = 5'd0;
      step(1);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return 32'h7FFFFFFF;
         5:       return 32'($urandom_range(255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      rd_in = 5'd0;
      step(1);
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;
      step(50);

      issue_lit("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
      issue_lit("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000);
      issue_lit("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE);
      issue_lit("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF);
      issue_lit("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7, 32'hFFFFFFFD);
      issue_lit("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd7, 32'hFFFFFFFF);
      issue_lit("divu",   3'b101, 32'd300,      32'd150,      5'd9, 32'd2);
      issue_lit("remu",   3'b111, 32'd53,       32'd10,       5'd9, 32'd3);
      issue_lit("divu0",  3'b101, 32'd5,        32'd0,        5'd1, 32'hFFFFFFFF);
      issue_lit("remu0",  3'b111, 32'd5,        32'd0,        5'd1, 32'd5);
      issue_lit("div0s",  3'b100, 32'hFFFFFFF0, 32'd0,        5'd2, 32'hFFFFFFFF);
      issue_lit("rem0s",  3'b110, 32'hFFFFFFF0, 32'd0,        5'd2, 32'hFFFFFFF0);
      issue_lit("divov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000);
      issue_lit("remov",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'd0);
      issue_lit("mul_x0", 3'b000, 32'd6,        32'd7,        5'd0, 32'd42);

      // start while busy is ignored
      issue(3'b000, 32'd11, 32'd13, 5'd4);
      step(9);
      issue(3'b101, 32'd1000, 32'd7, 5'd8);
      step(30);

      // start in the done cycle is accepted back-to-back
      issue(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd10);
      step(33);
      issue(3'b110, 32'hFFFF0001, 32'd17, 5'd11);
      step(36);

      // reset mid-operation aborts with no done
      issue(3'b001, 32'hDEADBEEF, 32'h01234567, 5'd12);
      step(9);
      do_reset();
      step(40);

      // randomized traffic, including starts while busy and in done cycles
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(2) == 0) begin
            issue(3'($urandom_range(7)), rand_opnd(), rand_opnd(), 5'($urandom_range(31)));
         end else begin
            step(1);
         end
      end
      step(40);
      check("drain", 32'(pend_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
